csa_add_scheduler: RTL

// - Shares one external 16-bit carry-select adder (variable_csa) between two requesters.
// - Each request is a WORDS*16-bit add.
// - The add runs one 16-bit slice per cycle, LSB slice first.
// - The slice carry is chained through a register between slices.
// - The block sits between client logic and the combinational adder.
// - It owns: arbitration, operand slicing, carry sequencing, result assembly and the response handshake.

---
 rtl/csa_add_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/csa_add_scheduler.sv
// Time-shares one external SLICE_W-bit adder between two requesters, adding WORDS slices LSB first with a registered carry chain.
// Optional round-robin arbitration when CSA_SCHED_RR_EN is defined; fixed priority to requester 0 otherwise.
module csa_add_scheduler #(
    parameter int WORDS   = 4,
    parameter int SLICE_W = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [SLICE_W*WORDS-1:0] req0_a_i,
    input  logic [SLICE_W*WORDS-1:0] req0_b_i,
    input  logic                 req0_cin_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [SLICE_W*WORDS-1:0] req1_a_i,
    input  logic [SLICE_W*WORDS-1:0] req1_b_i,
    input  logic                 req1_cin_i,
    output logic [SLICE_W-1:0]   add_a_o,
    output logic [SLICE_W-1:0]   add_b_o,
    output logic                 add_cin_o,
    input  logic [SLICE_W-1:0]   add_sum_i,
    input  logic                 add_carry_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_id_o,
    output logic [SLICE_W*WORDS-1:0] resp_sum_o,
    output logic                 resp_carry_o,
    output logic                 busy_o
);
    localparam int OPW  = SLICE_W * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [OPW-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            cin_q, cin_d, carry_q, carry_d, id_q, id_d;
    logic            gnt0, gnt1, can_accept, xfer, sel;

    // Grants are gated by reset so nothing appears accepted during a reset cycle.
    assign can_accept = (state_q == IDLE) && !reset_i;

`ifdef CSA_SCHED_RR_EN
    logic rr_q, rr_d;

    assign gnt0 = req0_valid_i && (!req1_valid_i || !rr_q);
    assign gnt1 = req1_valid_i && (!req0_valid_i || rr_q);
    assign rr_d = xfer ? !sel : rr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) rr_q <= 1'b0;
        else         rr_q <= rr_d;
    end
`else
    assign gnt0 = req0_valid_i;
    assign gnt1 = req1_valid_i && !req0_valid_i;
`endif

    assign req0_ready_o = can_accept && gnt0;
    assign req1_ready_o = can_accept && gnt1;
    assign xfer         = req0_ready_o || req1_ready_o;
    assign sel          = req1_ready_o;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        id_d    = id_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    a_d     = sel ? req1_a_i   : req0_a_i;
                    b_d     = sel ? req1_b_i   : req0_b_i;
                    cin_d   = sel ? req1_cin_i : req0_cin_i;
                    id_d    = sel;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = add_sum_i;
                carry_d = add_carry_i;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // The first slice takes the requester's carry-in; later slices chain the registered carry.
    assign add_a_o   = (state_q == RUN) ? a_q[idx_q*SLICE_W +: SLICE_W] : '0;
    assign add_b_o   = (state_q == RUN) ? b_q[idx_q*SLICE_W +: SLICE_W] : '0;
    assign add_cin_o = (state_q == RUN) && ((idx_q == '0) ? cin_q : carry_q);

    assign resp_valid_o = (state_q == DONE);
    assign resp_sum_o   = sum_q;
    assign resp_carry_o = carry_q;
    assign resp_id_o    = id_q;
    assign busy_o       = (state_q == RUN) || (state_q == DONE);
endmodule
